serial_merge: RTL and testbench

SERIAL_MERGE -- requirements
Module: serial_merge

---
 rtl/serial_merge.sv | 269 ++++++++++++++++++++++++++
 tb/tb_serial_merge.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_merge.sv
// serial_merge: merges CHANNELS 8N1 serial sources into one CPU rx line.
// Fans the CPU tx line back out to every channel.
// Ports:
//   clk_in      system clock, all state on its rising edge
//   rst_in      asynchronous active-low reset
//   rxd_in      per-channel 8N1 serial inputs, idle high
//   cpu_txd_in  CPU transmit line
//   cpu_rxd_out merged 8N1 stream to the CPU receive line
//   txd_out     per-channel copy of cpu_txd_in, one cycle late
//   busy_out    merge transmitter is not idle
//   overrun_out sticky per-channel overrun flags
// Macro SERIAL_MERGE_OVERRUN_EN enables overrun flag storage;
// when undefined overrun_out is tied low.
module serial_merge #(
  parameter int CHANNELS = 2,
  parameter int BIT_CLKS = 5208
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [CHANNELS-1:0] rxd_in,
  input  logic                cpu_txd_in,
  output logic                cpu_rxd_out,
  output logic [CHANNELS-1:0] txd_out,
  output logic                busy_out,
  output logic [CHANNELS-1:0] overrun_out
);

  localparam int CW = $clog2(BIT_CLKS);
  localparam int PW =
    (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] HALF_M1 =
    CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(BIT_CLKS - 1);

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE, T_START, T_DATA, T_STOP
  } tx_state_t;

  logic [CHANNELS-1:0]       rx_ok;
  logic [CHANNELS-1:0][7:0]  rx_byte;
  logic [CHANNELS-1:0][7:0]  hold;
  logic [CHANNELS-1:0]       full;
  logic [CHANNELS-1:0]       clr;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_rx
    logic      s1, s2, s3;
    rx_state_t st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bi, bi_n;
    logic [7:0] sh, sh_n;
    logic       ok;

    // s1/s2 synchronise; s3 only delays s2 for
    // falling-edge detection.
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        s1  <= 1'b1;
        s2  <= 1'b1;
        s3  <= 1'b1;
        st  <= R_IDLE;
        cnt <= '0;
        bi  <= '0;
        sh  <= '0;
      end else begin
        s1  <= rxd_in[i];
        s2  <= s1;
        s3  <= s2;
        st  <= st_n;
        cnt <= cnt_n;
        bi  <= bi_n;
        sh  <= sh_n;
      end
    end

    always_comb begin
      st_n  = st;
      cnt_n = cnt + 1'b1;
      bi_n  = bi;
      sh_n  = sh;
      ok    = 1'b0;
      unique case (st)
        R_IDLE: begin
          cnt_n = '0;
          if (s3 && !s2) st_n = R_START;
        end
        R_START: begin
          if (cnt == HALF_M1) begin
            cnt_n = '0;
            bi_n  = '0;
            st_n  = s2 ? R_IDLE : R_DATA;
          end
        end
        R_DATA: begin
          if (cnt == FULL_M1) begin
            cnt_n = '0;
            sh_n  = {s2, sh[7:1]};
            bi_n  = bi + 3'd1;
            if (bi == 3'd7) st_n = R_STOP;
          end
        end
        R_STOP: begin
          if (cnt == FULL_M1) begin
            cnt_n = '0;
            st_n  = R_IDLE;
            ok    = s2;
          end
        end
        default: st_n = R_IDLE;
      endcase
    end

    assign rx_ok[i]   = ok;
    assign rx_byte[i] = sh;
  end

  // A clear in the same cycle frees the slot,
  // so the arriving byte is taken.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      full <= '0;
      hold <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (rx_ok[i] && (!full[i] || clr[i])) begin
          full[i] <= 1'b1;
          hold[i] <= rx_byte[i];
        end else if (clr[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

`ifdef SERIAL_MERGE_OVERRUN_EN
  logic [CHANNELS-1:0] ovr;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ovr <= '0;
    end else begin
      ovr <= ovr | (rx_ok & full & ~clr);
    end
  end

  assign overrun_out = ovr;
`else
  assign overrun_out = '0;
`endif

  logic [PW-1:0] ptr, ptr_n, sel;
  logic          any;

  // First full channel at or after ptr, wrapping.
  always_comb begin
    int idx;
    idx = 0;
    sel = '0;
    any = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (!any && full[PW'(idx)]) begin
        any = 1'b1;
        sel = PW'(idx);
      end
    end
  end

  tx_state_t     ts, ts_n;
  logic [CW-1:0] tc, tc_n;
  logic [2:0]    tb, tb_n;
  logic [7:0]    tsh, tsh_n;
  logic          line, line_n;
  logic          take;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ts   <= T_IDLE;
      tc   <= '0;
      tb   <= '0;
      tsh  <= '0;
      line <= 1'b1;
      ptr  <= '0;
    end else begin
      ts   <= ts_n;
      tc   <= tc_n;
      tb   <= tb_n;
      tsh  <= tsh_n;
      line <= line_n;
      ptr  <= ptr_n;
    end
  end

  // line_n is the value the line takes for the
  // next cycle, so every bit edge is registered.
  always_comb begin
    ts_n   = ts;
    tc_n   = tc + 1'b1;
    tb_n   = tb;
    tsh_n  = tsh;
    line_n = line;
    ptr_n  = ptr;
    take   = 1'b0;
    clr    = '0;
    unique case (ts)
      T_IDLE: begin
        tc_n   = '0;
        line_n = 1'b1;
        take   = any;
      end
      T_START: begin
        if (tc == FULL_M1) begin
          tc_n   = '0;
          tb_n   = '0;
          ts_n   = T_DATA;
          line_n = tsh[0];
        end
      end
      T_DATA: begin
        if (tc == FULL_M1) begin
          tc_n = '0;
          if (tb == 3'd7) begin
            ts_n   = T_STOP;
            line_n = 1'b1;
          end else begin
            tb_n   = tb + 3'd1;
            tsh_n  = {1'b0, tsh[7:1]};
            line_n = tsh[1];
          end
        end
      end
      T_STOP: begin
        if (tc == FULL_M1) begin
          tc_n = '0;
          ts_n = T_IDLE;
          take = any;
        end
      end
      default: ts_n = T_IDLE;
    endcase
    // Chaining STOP straight into START keeps
    // exactly one stop period between frames.
    if (take) begin
      ts_n   = T_START;
      tc_n   = '0;
      tsh_n  = hold[sel];
      line_n = 1'b0;
      clr[sel] = 1'b1;
      ptr_n  = (int'(sel) == CHANNELS - 1) ?
               '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      txd_out <= '1;
    end else begin
      txd_out <= {CHANNELS{cpu_txd_in}};
    end
  end

  assign cpu_rxd_out = line;
  assign busy_out    = (ts != T_IDLE);

endmodule

// File: tb/tb_serial_merge.sv
// tb_serial_merge: directed bench for serial_merge.
// Two channels, 16 clocks per bit.
module tb_serial_merge;

  localparam int B = 16;

`ifdef SERIAL_MERGE_OVERRUN_EN
  localparam logic [1:0] OVR = 2'b01;
`else
  localparam logic [1:0] OVR = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rxd;
  logic       cpu_txd;
  logic       cpu_rxd;
  logic [1:0] txd;
  logic       busy;
  logic [1:0] ovr;

  int vec  = 0;
  int errs = 0;
  int cyc  = 0;
  int blo  = 0;
  int rst_cnt = 0;
  int nf;
  logic [8:0] frm [64];
  int         tst [64];

  serial_merge #(
    .CHANNELS (2),
    .BIT_CLKS (B)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst_n),
    .rxd_in      (rxd),
    .cpu_txd_in  (cpu_txd),
    .cpu_rxd_out (cpu_rxd),
    .txd_out     (txd),
    .busy_out    (busy),
    .overrun_out (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (busy !== 1'b1) blo <= blo + 1;

  always @(negedge rst_n) rst_cnt <= rst_cnt + 1;

  // Frame decoder on cpu_rxd: records {stop, data}
  // and the cycle count when the start bit showed.
  initial begin : mon
    int t0, r0;
    logic [8:0] f;
    logic ok;
    nf = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && cpu_rxd === 1'b0) begin
        t0 = cyc;
        r0 = rst_cnt;
        repeat (B / 2) @(negedge clk);
        ok = (cpu_rxd === 1'b0);
        for (int i = 0; i < 9; i++) begin
          repeat (B) @(negedge clk);
          f[i] = cpu_rxd;
        end
        if (ok && rst_cnt == r0) begin
          frm[nf] = f;
          tst[nf] = t0;
          nf = nf + 1;
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  // Drives one frame on each enabled channel; ch0 stop
  // bit value and stop length are selectable.
  task automatic send(input logic [7:0] d0,
                      input logic [7:0] d1,
                      input logic [1:0] en,
                      input logic       stp,
                      input int         stop_len);
    logic [9:0] f0, f1;
    f0 = {stp, d0, 1'b0};
    f1 = {1'b1, d1, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd[0] = en[0] ? f0[k] : 1'b1;
      rxd[1] = en[1] ? f1[k] : 1'b1;
      repeat ((k == 9) ? stop_len : B) @(negedge clk);
    end
    rxd = 2'b11;
  endtask

  task automatic wait_nf(input int n);
    for (int i = 0; i < 3000 && nf < n; i++)
      @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 1000 && busy; i++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    chk(tag, busy, 1'b0);
  endtask

  initial begin : seq
    int n0, cs, b0;
    logic [3:0] pat;
    logic prev;
    rst_n   = 1'b0;
    rxd     = 2'b11;
    cpu_txd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_line", cpu_rxd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_txd", txd, 2'b11);
    chk("rst_ovr", ovr, 2'b00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // single byte; start edge 2 cycles after the
    // stop sample, i.e. 156 cycles after start drive
    n0 = nf;
    cs = cyc;
    send(8'h41, 8'h00, 2'b01, 1'b1, B);
    chk("busy_41", busy, 1'b1);
    wait_nf(n0 + 1);
    chk("nf_41", nf, n0 + 1);
    chk("frm_41", frm[n0], {1'b1, 8'h41});
    chk("lat_41", tst[n0] - cs, 156);
    wait_idle("idle_41");

    // pointer now at ch1: C3 served first, 01 held,
    // 02 lands while 01 still held (dropped),
    // 03 lands after 01 was taken (kept)
    n0 = nf;
    cs = cyc;
    send(8'h01, 8'hC3, 2'b11, 1'b1, 12);
    send(8'h02, 8'h00, 2'b01, 1'b1, 12);
    send(8'h03, 8'h00, 2'b01, 1'b1, B);
    wait_nf(n0 + 3);
    chk("nf_ovr", nf, n0 + 3);
    chk("frm_c3", frm[n0], {1'b1, 8'hC3});
    chk("frm_01", frm[n0 + 1], {1'b1, 8'h01});
    chk("frm_03", frm[n0 + 2], {1'b1, 8'h03});
    chk("t_c3", tst[n0] - cs, 156);
    chk("t_01", tst[n0 + 1] - cs, 316);
    chk("t_03", tst[n0 + 2] - cs, 476);
    chk("ovr_set", ovr, OVR);
    wait_idle("idle_ovr");

    // framing error on ch0
    n0 = nf;
    send(8'hA5, 8'h00, 2'b01, 1'b0, B);
    repeat (300) @(negedge clk);
    chk("nf_ferr", nf, n0);
    chk("busy_ferr", busy, 1'b0);
    chk("ovr_ferr", ovr, OVR);

    // ch1 alone
    n0 = nf;
    send(8'h00, 8'h3C, 2'b10, 1'b1, B);
    wait_nf(n0 + 1);
    chk("frm_3c", frm[n0], {1'b1, 8'h3C});
    wait_idle("idle_3c");

    // simultaneous arrival, pointer back at ch0
    n0 = nf;
    cs = cyc;
    send(8'h55, 8'hAA, 2'b11, 1'b1, B);
    b0 = blo;
    repeat (310) @(negedge clk);
    chk("busy_gap", blo - b0, 0);
    chk("busy_2nd", busy, 1'b1);
    wait_nf(n0 + 2);
    chk("nf_b2b", nf, n0 + 2);
    chk("frm_55", frm[n0], {1'b1, 8'h55});
    chk("frm_aa", frm[n0 + 1], {1'b1, 8'hAA});
    chk("t_55", tst[n0] - cs, 156);
    chk("t_b2b", tst[n0 + 1] - tst[n0], 160);
    chk("ovr_sticky", ovr, OVR);
    wait_idle("idle_b2b");

    // tx fan-out, one cycle delay
    pat  = 4'b1101;
    prev = cpu_txd;
    for (int i = 0; i < 4; i++) begin
      cpu_txd = pat[i];
      #1;
      chk("txd_hold", txd, {prev, prev});
      @(negedge clk);
      chk("txd_dly", txd, {pat[i], pat[i]});
      prev = pat[i];
    end
    cpu_txd = 1'b1;
    repeat (2) @(negedge clk);

    // reset during DATA bit 3 of 0x7E
    n0 = nf;
    send(8'h7E, 8'h00, 2'b01, 1'b1, B);
    repeat (65) @(negedge clk);
    chk("busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mrst_line", cpu_rxd, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_txd", txd, 2'b11);
    chk("mrst_ovr", ovr, 2'b00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("nf_mrst", nf, n0);
    chk("line_mrst", cpu_rxd, 1'b1);
    chk("busy_mrst", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
